// File: rtl/batch_dispatcher.sv
// ============================================================================
// Module  : batch_dispatcher
// Brief   : Routes upstream batch groups round-robin onto NUM_FU functional
//           units. Optional watchdog is enabled by BATCH_DISPATCHER_TIMEOUT_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module batch_dispatcher #(
    parameter int NUM_FU         = 4,
    parameter int BATCH_WIDTH    = 128,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BATCH_WIDTH-1:0]        in_batch,
    input  logic                          in_last,
    output logic [NUM_FU*BATCH_WIDTH-1:0] fu_batch,
    output logic [NUM_FU-1:0]             fu_end_tag,
    input  logic [NUM_FU-1:0]             fu_done,
    output logic [NUM_FU-1:0]             fu_busy,
    output logic [15:0]                   groups_done,
    output logic                          idle,
    output logic [NUM_FU-1:0]             timeout_err
);

    localparam int         IW      = $clog2(NUM_FU);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OPEN = 1'b1;

    logic [0:0]                   r_state;
    logic [0:0]                   w_state_nxt;
    logic [IW-1:0]                r_rr;
    logic [IW-1:0]                r_cur;
    logic [NUM_FU-1:0]            r_busy;
    logic [NUM_FU*BATCH_WIDTH-1:0] r_fu_batch;
    logic [NUM_FU-1:0]            r_end_tag;
    logic [15:0]                  r_groups_done;

    logic                         w_xfer;
    logic [IW-1:0]                w_grant;
    logic [IW:0]                  w_sum;
    logic [IW-1:0]                w_tgt;
    logic [IW-1:0]                w_tgt_nxt;
    logic [NUM_FU-1:0]            w_done_ok;
    logic [NUM_FU-1:0]            w_to_hit;
    logic [NUM_FU-1:0]            w_set;
    logic [3:0]                   w_done_cnt;

    assign w_xfer = in_valid & in_ready;

    // Lowest offset from rr wins, so scan offsets from high to low.
    always_comb begin
        w_grant = r_rr;
        w_sum   = '0;
        for (int i = NUM_FU - 1; i >= 0; i--) begin
            w_sum = {1'b0, r_rr} + (IW+1)'(i);
            if (w_sum >= (IW+1)'(NUM_FU)) begin
                w_sum = w_sum - (IW+1)'(NUM_FU);
            end
            if (!r_busy[w_sum[IW-1:0]]) begin
                w_grant = w_sum[IW-1:0];
            end
        end
    end

    assign w_tgt     = (r_state == ST_IDLE) ? w_grant : r_cur;
    assign w_tgt_nxt = (w_tgt == IW'(NUM_FU - 1)) ? '0 : w_tgt + 1'b1;

    always_comb begin
        w_set      = '0;
        w_done_ok  = '0;
        w_done_cnt = '0;
        if (w_xfer && (r_state == ST_IDLE)) begin
            w_set[w_grant] = 1'b1;
        end
        for (int k = 0; k < NUM_FU; k++) begin
            w_done_ok[k] = fu_done[k] & r_busy[k] &
                           ~((r_state == ST_OPEN) && (r_cur == IW'(k)));
            w_done_cnt   = w_done_cnt + {3'b000, w_done_ok[k]};
        end
    end

    // FSM: state register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        if (w_xfer) begin
            w_state_nxt = in_last ? ST_IDLE : ST_OPEN;
        end
    end

    // FSM: outputs, derived from registered state only
    always_comb begin
        in_ready = (r_state == ST_OPEN) || (r_busy != {NUM_FU{1'b1}});
        idle     = (r_state == ST_IDLE) && (r_busy == '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr          <= '0;
            r_cur         <= '0;
            r_busy        <= '0;
            r_fu_batch    <= '0;
            r_end_tag     <= '0;
            r_groups_done <= '0;
        end else begin
            r_fu_batch    <= '0;
            r_end_tag     <= '0;
            r_busy        <= (r_busy & ~w_done_ok & ~w_to_hit) | w_set;
            r_groups_done <= r_groups_done + {12'h000, w_done_cnt};
            if (w_xfer) begin
                r_cur                                   <= w_tgt;
                r_fu_batch[w_tgt*BATCH_WIDTH +: BATCH_WIDTH] <= in_batch;
                if (in_last) begin
                    r_end_tag[w_tgt] <= 1'b1;
                    r_rr             <= w_tgt_nxt;
                end
            end
        end
    end

`ifdef BATCH_DISPATCHER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    for (genvar k = 0; k < NUM_FU; k++) begin : g_timeout
        logic [TW-1:0] r_cnt;
        logic          r_act;
        logic          r_err;

        // Counter runs from the end-tag cycle; a real done always wins.
        assign w_to_hit[k]    = r_act & (r_cnt == TW'(TIMEOUT_CYCLES - 1)) & ~w_done_ok[k];
        assign timeout_err[k] = r_err;

        always_ff @(posedge clock) begin
            if (reset) begin
                r_cnt <= '0;
                r_act <= 1'b0;
                r_err <= 1'b0;
            end else begin
                if (w_to_hit[k]) begin
                    r_err <= 1'b1;
                end
                if (w_done_ok[k] || w_to_hit[k]) begin
                    r_act <= 1'b0;
                    r_cnt <= '0;
                end else if (r_end_tag[k]) begin
                    r_act <= 1'b1;
                    r_cnt <= TW'(1);
                end else if (r_act) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end
`else
    assign w_to_hit    = '0;
    assign timeout_err = '0;
`endif

    assign fu_batch    = r_fu_batch;
    assign fu_end_tag  = r_end_tag;
    assign fu_busy     = r_busy;
    assign groups_done = r_groups_done;

endmodule

`default_nettype wire

// File: tb/tb_batch_dispatcher.sv
// ============================================================================
// Module  : tb_batch_dispatcher
// Brief   : Directed self-checking bench for batch_dispatcher (4 FUs, 16-bit).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_batch_dispatcher;

    localparam int NUM_FU = 4;
    localparam int BW     = 16;
    localparam int TO     = 8;
`ifdef BATCH_DISPATCHER_TIMEOUT_EN
    localparam logic TO_EN = 1'b1;
`else
    localparam logic TO_EN = 1'b0;
`endif

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   in_valid;
    logic                   in_ready;
    logic [BW-1:0]          in_batch;
    logic                   in_last;
    logic [NUM_FU*BW-1:0]   fu_batch;
    logic [NUM_FU-1:0]      fu_end_tag;
    logic [NUM_FU-1:0]      fu_done;
    logic [NUM_FU-1:0]      fu_busy;
    logic [15:0]            groups_done;
    logic                   idle;
    logic [NUM_FU-1:0]      timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    batch_dispatcher #(
        .NUM_FU         (NUM_FU),
        .BATCH_WIDTH    (BW),
        .TIMEOUT_CYCLES (TO)
    ) u_dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_batch    (in_batch),
        .in_last     (in_last),
        .fu_batch    (fu_batch),
        .fu_end_tag  (fu_end_tag),
        .fu_done     (fu_done),
        .fu_busy     (fu_busy),
        .groups_done (groups_done),
        .idle        (idle),
        .timeout_err (timeout_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_batch = '0;
        fu_done  = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    function automatic logic [63:0] slice(input int k, input logic [BW-1:0] v);
        logic [63:0] t;
        t = 64'(v);
        return t << (BW * k);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        // Reset state
        do_reset();
        step();
        check("rst_ready", in_ready, 1);
        check("rst_idle", idle, 1);
        check("rst_busy", fu_busy, 0);
        check("rst_gd", groups_done, 0);
        check("rst_batch", fu_batch, 0);
        check("rst_tag", fu_end_tag, 0);
        check("rst_err", timeout_err, 0);

        // Three-batch group lands on FU0
        in_valid = 1'b1; in_batch = 16'hA00A; in_last = 1'b0; step();
        check("g3_A", fu_batch, slice(0, 16'hA00A));
        check("g3_busy", fu_busy, 4'b0001);
        in_batch = 16'hB00B; step();
        check("g3_B", fu_batch, slice(0, 16'hB00B));
        check("g3_tagB", fu_end_tag, 0);
        in_batch = 16'hC00C; in_last = 1'b1; step();
        check("g3_C", fu_batch, slice(0, 16'hC00C));
        check("g3_tagC", fu_end_tag, 4'b0001);
        in_valid = 1'b0; in_last = 1'b0; step();
        check("g3_quiet", fu_batch, 0);
        check("g3_tag0", fu_end_tag, 0);
        check("g3_notidle", idle, 0);
        fu_done = 4'b0001; step(); fu_done = '0;
        check("g3_done_busy", fu_busy, 0);
        check("g3_done_gd", groups_done, 1);
        check("g3_done_idle", idle, 1);

        // Round-robin single-batch groups, then stall until FU1 frees
        do_reset();
        in_valid = 1'b1; in_last = 1'b1;
        for (int k = 0; k < NUM_FU; k++) begin
            in_batch = 16'h1000 + 16'(k);
            step();
            check("rr_tag", fu_end_tag, 64'(1) << k);
            check("rr_batch", fu_batch, slice(k, 16'h1000 + 16'(k)));
        end
        check("rr_full_ready", in_ready, 0);
        check("rr_full_busy", fu_busy, 4'b1111);
        in_batch = 16'h5555; step();
        check("stall_batch", fu_batch, 0);
        check("stall_ready", in_ready, 0);
        fu_done = 4'b0010; step(); fu_done = '0;
        check("free1_busy", fu_busy, 4'b1101);
        check("free1_ready", in_ready, 1);
        check("free1_batch", fu_batch, 0);
        step();
        check("fifth_batch", fu_batch, slice(1, 16'h5555));
        check("fifth_tag", fu_end_tag, 4'b0010);
        check("fifth_busy", fu_busy, 4'b1111);
        check("fifth_gd", groups_done, 1);
        in_valid = 1'b0; in_last = 1'b0;

        // Simultaneous dones and a done to an idle FU
        fu_done = 4'b1000; step();
        check("d3_busy", fu_busy, 4'b0111);
        check("d3_gd", groups_done, 2);
        fu_done = 4'b0101; step();
        check("d02_busy", fu_busy, 4'b0010);
        check("d02_gd", groups_done, 4);
        fu_done = 4'b1000; step(); fu_done = '0;
        check("dnop_busy", fu_busy, 4'b0010);
        check("dnop_gd", groups_done, 4);

        // Reset in the middle of an open group on FU2
        do_reset();
        in_valid = 1'b1; in_last = 1'b1;
        in_batch = 16'h0001; step();
        in_batch = 16'h0002; step();
        in_last = 1'b0; in_batch = 16'h002A; step();
        check("open2_A", fu_batch, slice(2, 16'h002A));
        in_batch = 16'h002B; step();
        check("open2_B", fu_batch, slice(2, 16'h002B));
        fu_done = 4'b0100;
        in_valid = 1'b0; step(); fu_done = '0;
        check("open_hold_batch", fu_batch, 0);
        check("open_hold_ready", in_ready, 1);
        check("open_cur_done_ignored", fu_busy, 4'b0111);
        reset = 1'b1; step(); reset = 1'b0;
        check("mrst_busy", fu_busy, 0);
        check("mrst_batch", fu_batch, 0);
        check("mrst_tag", fu_end_tag, 0);
        check("mrst_gd", groups_done, 0);
        check("mrst_ready", in_ready, 1);
        check("mrst_idle", idle, 1);
        in_valid = 1'b1; in_last = 1'b1; in_batch = 16'h0F0F; step();
        check("mrst_grant_tag", fu_end_tag, 4'b0001);
        check("mrst_grant_batch", fu_batch, slice(0, 16'h0F0F));
        in_valid = 1'b0; in_last = 1'b0;

        // Watchdog behaviour on FU0
        do_reset();
        in_valid = 1'b1; in_last = 1'b1; in_batch = 16'h7777; step();
        in_valid = 1'b0; in_last = 1'b0;
        repeat (TO - 1) step();
        check("to_busy_pre", fu_busy[0], 1);
        step();
        check("to_busy", fu_busy[0], !TO_EN);
        check("to_err", timeout_err[0], TO_EN);
        check("to_gd", groups_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/batch_dispatcher.md
BATCH_DISPATCHER -- requirements
Module: batch_dispatcher

Interface
REQ-001 The block SHALL have parameter NUM_FU, default 4, giving the number of functional units served (2..8).
REQ-002 The block SHALL have parameter BATCH_WIDTH, default 128, giving the width of one batch.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 64, giving the watchdog limit in cycles.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 in_valid  input  1  upstream batch valid.
REQ-007 in_ready  output  1  dispatcher accepts the batch this cycle.
REQ-008 in_batch  input  BATCH_WIDTH  batch payload.
REQ-009 in_last  input  1  batch closes the current group.
REQ-010 fu_batch  output  NUM_FU*BATCH_WIDTH  per-FU batch bus; slice k drives FU k.
REQ-011 fu_end_tag  output  NUM_FU  per-FU end-of-group tag.
REQ-012 fu_done  input  NUM_FU  per-FU doneBatches pulse.
REQ-013 fu_busy  output  NUM_FU  FU k owns an open or in-flight group.
REQ-014 groups_done  output  16  count of completed groups.
REQ-015 idle  output  1  no group open and fu_busy all zero.
REQ-016 timeout_err  output  NUM_FU  sticky per-FU watchdog flag.

Function
REQ-017 A transfer SHALL occur on a rising edge with in_valid and in_ready both high; in_batch, in_last sampled then.
REQ-018 The FSM SHALL have states IDLE (no group open) and OPEN (group open on FU cur).
REQ-019 in_ready SHALL be 1 in OPEN, 1 in IDLE when any fu_busy bit is 0, else 0; combinational from registered state only.
REQ-020 IDLE transfer SHALL grant cur = first FU with fu_busy=0 searching rr, rr+1, ... modulo NUM_FU; fu_busy[cur] set next cycle.
REQ-021 IDLE transfer with in_last=0 SHALL go to OPEN; with in_last=1 SHALL stay IDLE (single-batch group).
REQ-022 OPEN transfer SHALL route to cur; in_last=1 returns to IDLE; rr SHALL become cur+1 mod NUM_FU when a group closes.
REQ-023 Each transferred batch SHALL appear on fu_batch slice cur for exactly the one cycle after the transfer edge (latency 1); all other slices, and slice cur in non-transfer cycles, SHALL be zero.
REQ-024 fu_end_tag[cur] SHALL pulse for one cycle aligned with the in_last batch on fu_batch; otherwise 0.
REQ-025 fu_busy[k] SHALL clear on the edge after fu_done[k]=1; groups_done increments by 1 per cleared FU-group, wrapping 0xFFFF->0x0000; multiple simultaneous dones add their count.
REQ-026 fu_done[k] while fu_busy[k]=0, or while k is cur in OPEN, SHALL be ignored.
REQ-027 An FU whose fu_busy clears in a cycle SHALL NOT be grantable until the following cycle (grant uses registered fu_busy).
REQ-028 in_valid=0 in OPEN SHALL hold OPEN indefinitely with zero batches driven.

Reset
REQ-029 On reset (including mid-group): state IDLE, rr=0, cur=0, fu_busy=0, fu_batch=0, fu_end_tag=0, groups_done=0, timeout_err=0, idle=1, in_ready=1 the cycle after reset deasserts; in-flight groups are abandoned, no dones counted.

Configuration
REQ-030 With macro BATCH_DISPATCHER_TIMEOUT_EN defined, a per-FU counter SHALL start at the fu_end_tag[k] pulse; if fu_done[k] is not seen before it reaches TIMEOUT_CYCLES, fu_busy[k] clears, timeout_err[k] sets (sticky until reset), groups_done does not increment.
REQ-031 Without BATCH_DISPATCHER_TIMEOUT_EN, no counters SHALL exist, timeout_err SHALL be tied 0, and fu_busy[k] clears only via fu_done[k].

Verification
REQ-032 Reset, one group of 3 batches (A,B,C, last on C) -> slice 0 shows A,B,C on consecutive cycles, fu_end_tag=0001 with C, fu_busy=0001.
REQ-033 Four single-batch groups back-to-back, no dones -> granted FU0,1,2,3; fifth in_valid sees in_ready=0 until fu_done[1] then goes to FU1 one cycle after busy clears.
REQ-034 fu_done=0101 in one cycle with FU0,FU2 busy -> fu_busy clears both, groups_done +2; fu_done[3] while FU3 idle -> no change.
REQ-035 Reset asserted during OPEN on FU2 after 2 batches -> all outputs at reset values next cycle, following group granted FU0.
REQ-036 With BATCH_DISPATCHER_TIMEOUT_EN, TIMEOUT_CYCLES=8, no fu_done after end tag on FU0 -> fu_busy[0] clears and timeout_err[0]=1 after 8 cycles, groups_done unchanged; without macro, fu_busy[0] stays 1.
